// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter at DIV clocks/bit (8E1 when UART_TX_PARITY_EN is defined); tx/busy registered, tx drops on the accept edge.
// Backpressure: in_ready is high only in IDLE out of reset; in_valid is ignored while a frame is in flight.
module uart_tx #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    localparam int TW = $clog2(DIV);
    localparam logic [TW-1:0] TMAX = TW'(DIV - 1);
    localparam logic [TW-1:0] TONE = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_state;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx;
    logic [7:0]      r_data;
    logic [7:0]      w_data;
    logic            r_tx;
    logic            w_tx;
    logic            r_busy;
    logic            w_busy;
    logic            w_expire;

    assign w_expire = (r_timer == '0);
    assign in_ready = (r_state == S_IDLE) && !rst;
    assign tx       = r_tx;
    assign busy     = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_timer <= w_timer;
            r_idx   <= w_idx;
            r_data  <= w_data;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
        end
    end

    // Every transition also computes the next line level so tx is registered with no added latency.
    always_comb begin
        w_state = r_state;
        w_timer = r_timer;
        w_idx   = r_idx;
        w_data  = r_data;
        w_tx    = r_tx;
        w_busy  = r_busy;
        case (r_state)
            S_IDLE: begin
                w_tx   = 1'b1;
                w_busy = 1'b0;
                if (in_valid) begin
                    w_state = S_START;
                    w_data  = in_data;
                    w_timer = TMAX;
                    w_idx   = '0;
                    w_tx    = 1'b0;
                    w_busy  = 1'b1;
                end
            end
            S_START: begin
                if (w_expire) begin
                    w_state = S_DATA;
                    w_timer = TMAX;
                    w_tx    = r_data[0];
                end else begin
                    w_timer = r_timer - TONE;
                end
            end
            S_DATA: begin
                if (w_expire) begin
                    w_timer = TMAX;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state = S_PARITY;
                        w_tx    = ^r_data;
`else
                        w_state = S_STOP;
                        w_tx    = 1'b1;
`endif
                    end else begin
                        w_idx = r_idx + 3'd1;
                        w_tx  = r_data[r_idx + 3'd1];
                    end
                end else begin
                    w_timer = r_timer - TONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_expire) begin
                    w_state = S_STOP;
                    w_timer = TMAX;
                    w_tx    = 1'b1;
                end else begin
                    w_timer = r_timer - TONE;
                end
            end
`endif
            S_STOP: begin
                w_tx = 1'b1;
                if (w_expire) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                end else begin
                    w_timer = r_timer - TONE;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table-driven frames checked against a scoreboard by a per-cycle line monitor,
// plus hand sequences for reset, ready timing, data stability and mid-frame abort.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBIT = 11;
`else
    localparam int NBIT = 10;
`endif
    localparam int FL = NBIT * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;

    uart_tx #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         spacing;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        int         gap;
        logic       par;
    } vec_t;

    exp_t sb[$];
    bit   mon_en = 1'b1;
    int   last_start = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] frame_wave(input logic [7:0] d, input logic p);
        logic [63:0] w;
        int b;
        w = '0;
        for (int i = 0; i <= FL; i++) begin
            b = i / DIV;
            if (i == FL)                     w[i] = 1'b1;
            else if (b == 0)                 w[i] = 1'b0;
            else if (b <= 8)                 w[i] = d[b-1];
            else if (NBIT == 11 && b == 9)   w[i] = p;
            else                             w[i] = 1'b1;
        end
        return w;
    endfunction

    // Line monitor: captures FL frame samples plus the following idle sample, one per cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst && tx === 1'b0) begin
                logic [63:0] got_tx;
                logic [63:0] got_busy;
                exp_t        e;
                int          sc;
                sc = cyc;
                got_tx = '0;
                got_busy = '0;
                got_tx[0] = tx;
                got_busy[0] = busy;
                for (int i = 1; i <= FL; i++) begin
                    @(negedge clk);
                    got_tx[i] = tx;
                    got_busy[i] = busy;
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: frame started at cycle %0d, required none", sc);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("frame_tx_%02h", e.data), got_tx, frame_wave(e.data, e.par));
                    check($sformatf("frame_busy_%02h", e.data), got_busy, (64'd1 << FL) - 64'd1);
                    if (e.spacing != 0)
                        check($sformatf("frame_spacing_%02h", e.data), 64'(sc - last_start), 64'(e.spacing));
                end
                last_start = sc;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic p, input int sp, input bit push, output int waited);
        in_data = d;
        in_valid = 1'b1;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) sb.push_back('{data: d, par: p, spacing: sp});
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   w;
        int   n;
        vecs[0] = '{data: 8'hA5, gap: 1, par: 1'b0};
        vecs[1] = '{data: 8'h00, gap: 0, par: 1'b0};
        vecs[2] = '{data: 8'hFF, gap: 0, par: 1'b0};
        vecs[3] = '{data: 8'h07, gap: 3, par: 1'b1};
        vecs[4] = '{data: 8'h03, gap: 0, par: 1'b0};
        vecs[5] = '{data: 8'h80, gap: 2, par: 1'b1};
        vecs[6] = '{data: 8'h01, gap: 0, par: 1'b1};

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", 64'({tx, busy, in_ready}), 64'h4);
        end
        rst = 1'b0;
        #1;
        check("ready_after_release", 64'(in_ready), 64'h1);
        @(negedge clk);
        check("idle_outputs", 64'({tx, busy, in_ready}), 64'h5);

        // Single 0xA5: in_ready must stay low through cycle 39 and return at cycle 40
        send(8'hA5, 1'b0, 0, 1'b1, w);
        in_valid = 1'b0;
        repeat (FL - 1) @(posedge clk);
        @(negedge clk);
        check("ready_before_end", 64'(in_ready), 64'h0);
        @(posedge clk);
        @(negedge clk);
        check("ready_at_end", 64'(in_ready), 64'h1);

        // Table: gap==0 entries keep in_valid high so they follow back-to-back
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].gap > 0) begin
                in_valid = 1'b0;
                wait_idle();
                repeat (vecs[i].gap) @(negedge clk);
            end
            send(vecs[i].data, vecs[i].par, (vecs[i].gap == 0) ? FL + 1 : 0, 1'b1, w);
        end
        in_valid = 1'b0;

        // Data stability: in_data changes one cycle after acceptance
        wait_idle();
        send(8'h55, 1'b0, 0, 1'b1, w);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        in_data = 8'hAA;

        // Mid-frame reset during data bit 3 of 0x3C, then 0x81 accepted on the first edge
        wait_idle();
        mon_en = 1'b0;
        send(8'h3C, 1'b0, 0, 1'b0, w);
        in_valid = 1'b0;
        repeat (4 * DIV + 1) @(posedge clk);
        @(negedge clk);
        check("busy_before_abort", 64'({tx, busy}), 64'h3);
        rst = 1'b1;
        #1;
        check("abort_outputs", 64'({tx, busy, in_ready}), 64'h4);
        in_data = 8'h81;
        in_valid = 1'b1;
        mon_en = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check("ready_after_abort", 64'(in_ready), 64'h1);
        @(posedge clk);
        sb.push_back('{data: 8'h81, par: 1'b0, spacing: 0});
        #1;
        check("accept_first_edge", 64'({tx, busy}), 64'h1);
        in_valid = 1'b0;

        // Drain the scoreboard
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'h0);
        wait_idle();
        check("final_idle", 64'({tx, busy, in_ready}), 64'h5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DIV, default 4, clock cycles per serial bit; the block SHALL support DIV >= 2.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: in_data  input  8  byte to transmit, e.g. the free-running count from the upstream counter.
REQ-005 Port: in_valid  input  1  in_data holds a byte to send.
REQ-006 Port: in_ready  output  1  block can accept a byte this cycle.
REQ-007 Port: tx  output  1  serial line, idle high, registered.
REQ-008 Port: busy  output  1  high while a frame is in progress, registered.

Function
REQ-009 The block SHALL implement states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-010 in_ready SHALL be 1 exactly when the state is IDLE and rst is 0.
REQ-011 A byte SHALL be accepted on a rising edge with in_valid=1 and in_ready=1, and in_data SHALL be latched at that edge.
REQ-012 Changes on in_data after acceptance SHALL NOT affect the frame in progress.
REQ-013 On acceptance: state goes to START, and tx=0 and busy=1 SHALL take effect on the same edge (zero added latency).
REQ-014 Each of START, every data bit, PARITY and STOP SHALL drive tx for exactly DIV cycles, using a bit timer that counts DIV-1 down to 0.
REQ-015 DATA SHALL send bits 0..7 LSB first, tracked by a 3-bit index; the state SHALL move to PARITY/STOP after index 7 expires, never wrapping back to bit 0.
REQ-016 STOP SHALL drive tx=1; when its timer expires, state SHALL return to IDLE and busy SHALL fall.
REQ-017 Back-to-back: if in_valid is high in the first IDLE cycle after STOP, the next START SHALL begin one cycle after STOP ends, giving a frame period of 10*DIV+1 cycles (11*DIV+1 with parity).
REQ-018 in_valid deasserted while in_ready=0 SHALL be legal and ignored.
REQ-019 In IDLE, tx SHALL be 1 and busy SHALL be 0.

Reset
REQ-020 While rst=1: state=IDLE, tx=1, busy=0, in_ready=0, and the timer, bit index and data latch SHALL be 0, asynchronously.
REQ-021 Reset asserted mid-frame SHALL abort the frame immediately; tx=1 with no partial stop bit.
REQ-022 After rst falls, the block SHALL accept a new byte on the first rising edge.

Configuration
REQ-023 Macro UART_TX_PARITY_EN defined: a PARITY state SHALL follow DATA and drive the even-parity bit (XOR of the 8 data bits) for DIV cycles; frame length is 11*DIV cycles.
REQ-024 Macro UART_TX_PARITY_EN undefined: DATA SHALL go directly to STOP, no parity logic is present, and frame length is 10*DIV cycles.

Verification
REQ-025 Reset, DIV=4: hold rst=1 for 3 cycles -> tx=1, busy=0, in_ready=0 throughout; in_ready=1 on the first edge after release.
REQ-026 Single byte 0xA5, DIV=4, no parity: line sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high 40 cycles; in_ready returns 1 at cycle 40.
REQ-027 Back-to-back 0x00 then 0xFF with in_valid held high: second start bit begins 41 cycles after the first, no idle bit between frames; both bytes decode correctly.
REQ-028 Reset mid-frame: rst pulsed during data bit 3 of 0x3C -> tx=1 and busy=0 with no clock edge required; next byte 0x81 is then sent complete and correct.
REQ-029 With UART_TX_PARITY_EN: 0x07 sends parity bit 1 and 0x03 sends parity bit 0; each frame is 44 cycles at DIV=4.
REQ-030 Data stability: in_data changed from 0x55 to 0xAA one cycle after acceptance -> 0x55 is transmitted.
